// File: rtl/ahb_sram_responder.sv
// AHB-Lite responder backed by a word-organised on-chip SRAM.
// Handles byte/halfword/word writes, programmable wait states and ERROR replies.
module ahb_sram_responder #(
    parameter int unsigned MEM_DEPTH_LOG2 = 10,
    parameter logic [31:0] BASE_ADDR      = 32'h0000_0000,
    parameter int unsigned WAIT_CYCLES    = 0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        HSEL,
    input  logic [31:0] HADDR,
    input  logic        HWRITE,
    input  logic [2:0]  HSIZE,
    input  logic [2:0]  HBURST,
    input  logic [1:0]  HTRANS,
    input  logic        HMASTLOCK,
    input  logic [31:0] HWDATA,
    input  logic        HREADY,
    output logic [31:0] HRDATA,
    output logic        HREADYOUT,
    output logic [1:0]  HRESP
);

    localparam int unsigned AW = MEM_DEPTH_LOG2 + 2;
    localparam int unsigned DEPTH = 1 << MEM_DEPTH_LOG2;
    localparam logic [31:0] WIN_MASK = ~((32'd1 << AW) - 32'd1);
    localparam logic [3:0] WAIT_INIT =
        (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

    typedef enum logic [2:0] {
        S_IDLE, S_WAIT, S_DATA, S_ERR1, S_ERR2
    } state_e;

    state_e            state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic [AW-1:0]     addr_q;
    logic              write_q;
    logic [1:0]        size_q;
    logic              rdy_q;
    logic [1:0]        resp_q;

    logic [31:0]       mem [DEPTH];
    logic [MEM_DEPTH_LOG2-1:0] widx;
    logic [3:0]        be;
    logic              accept, size_ok, in_win, legal;
    logic              unused_ok;

    assign unused_ok = ^{HTRANS[0], HBURST, HMASTLOCK};

    // Address phases are only taken while the current data phase is completing.
    assign accept  = HSEL & HREADY & HTRANS[1] & rdy_q;
    assign size_ok = (HSIZE == 3'd0)
                   | ((HSIZE == 3'd1) & ~HADDR[0])
                   | ((HSIZE == 3'd2) & (HADDR[1:0] == 2'b00));
    assign in_win  = (HADDR & WIN_MASK) == BASE_ADDR;
    assign legal   = size_ok & in_win;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            S_WAIT: begin
                if (cnt_q == 4'd0) state_d = S_DATA;
                else               cnt_d   = cnt_q - 4'd1;
            end
            S_ERR1: state_d = S_ERR2;
            default: begin
                if (!accept) begin
                    state_d = S_IDLE;
                end else if (!legal) begin
                    state_d = S_ERR1;
                end else if (WAIT_CYCLES > 0) begin
                    state_d = S_WAIT;
                    cnt_d   = WAIT_INIT;
                end else begin
                    state_d = S_DATA;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= 4'd0;
            addr_q  <= '0;
            write_q <= 1'b0;
            size_q  <= 2'd0;
            rdy_q   <= 1'b1;
            resp_q  <= 2'b00;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rdy_q   <= (state_d != S_WAIT) && (state_d != S_ERR1);
            resp_q  <= ((state_d == S_ERR1) || (state_d == S_ERR2))
                       ? 2'b01 : 2'b00;
            if (accept) begin
                addr_q  <= HADDR[AW-1:0];
                write_q <= HWRITE;
                size_q  <= HSIZE[1:0];
            end
        end
    end

    assign widx = addr_q[AW-1:2];

    always_comb begin
        be = 4'b0000;
        unique case (size_q)
            2'd0:    be[addr_q[1:0]] = 1'b1;
            2'd1:    be = addr_q[1] ? 4'b1100 : 4'b0011;
            default: be = 4'b1111;
        endcase
    end

    // Lanes are written in place from the matching HWDATA byte lane.
    always_ff @(posedge clk) begin
        if ((state_q == S_DATA) && write_q) begin
            for (int i = 0; i < 4; i++) begin
                if (be[i]) mem[widx][8*i +: 8] <= HWDATA[8*i +: 8];
            end
        end
    end

    assign HRDATA    = ((state_q == S_DATA) && !write_q) ? mem[widx] : 32'd0;
    assign HREADYOUT = rdy_q;
    assign HRESP     = resp_q;

endmodule

// File: tb/tb_ahb_sram_responder.sv
// Directed bench for ahb_sram_responder at WAIT_CYCLES 0, 2 and 3.
// Per-cycle expectations are queued with the stimulus and checked in order.
module tb_ahb_sram_responder;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [2:0]  hsel;
    logic [31:0] haddr, hwdata;
    logic        hwrite;
    logic [2:0]  hsize;
    logic [1:0]  htrans;
    logic        hready;
    logic [1:0]  cur;
    logic [2:0]  rdy;
    logic [1:0]  resp [3];
    logic [31:0] rdata [3];

    always #5 clk = ~clk;

    assign hready = rdy[cur];

    ahb_sram_responder #(.WAIT_CYCLES(0)) u0 (
        .clk(clk), .rst_n(rst_n), .HSEL(hsel[0]), .HADDR(haddr),
        .HWRITE(hwrite), .HSIZE(hsize), .HBURST(3'b000), .HTRANS(htrans),
        .HMASTLOCK(1'b0), .HWDATA(hwdata), .HREADY(hready),
        .HRDATA(rdata[0]), .HREADYOUT(rdy[0]), .HRESP(resp[0])
    );

    ahb_sram_responder #(.WAIT_CYCLES(2)) u2 (
        .clk(clk), .rst_n(rst_n), .HSEL(hsel[1]), .HADDR(haddr),
        .HWRITE(hwrite), .HSIZE(hsize), .HBURST(3'b000), .HTRANS(htrans),
        .HMASTLOCK(1'b0), .HWDATA(hwdata), .HREADY(hready),
        .HRDATA(rdata[1]), .HREADYOUT(rdy[1]), .HRESP(resp[1])
    );

    ahb_sram_responder #(.WAIT_CYCLES(3)) u3 (
        .clk(clk), .rst_n(rst_n), .HSEL(hsel[2]), .HADDR(haddr),
        .HWRITE(hwrite), .HSIZE(hsize), .HBURST(3'b000), .HTRANS(htrans),
        .HMASTLOCK(1'b0), .HWDATA(hwdata), .HREADY(hready),
        .HRDATA(rdata[2]), .HREADYOUT(rdy[2]), .HRESP(resp[2])
    );

    typedef struct {
        string       tag;
        int          d;
        logic        rdy;
        logic [1:0]  resp;
        logic [31:0] rdata;
    } exp_t;

    exp_t sb [$];
    int   compared = 0;
    int   mism = 0;

    task automatic push(input string tag, input int d, input logic r,
                        input logic [1:0] rs, input logic [31:0] rd);
        exp_t e;
        e.tag = tag; e.d = d; e.rdy = r; e.resp = rs; e.rdata = rd;
        sb.push_back(e);
    endtask

    task automatic check(input exp_t e);
        compared++;
        assert (rdy[e.d] === e.rdy) else begin
            mism++;
            $error("FAIL %s hreadyout got %0b want %0b", e.tag, rdy[e.d], e.rdy);
        end
        compared++;
        assert (resp[e.d] === e.resp) else begin
            mism++;
            $error("FAIL %s hresp got %0b want %0b", e.tag, resp[e.d], e.resp);
        end
        compared++;
        assert (rdata[e.d] === e.rdata) else begin
            mism++;
            $error("FAIL %s hrdata got %h want %h", e.tag, rdata[e.d], e.rdata);
        end
    endtask

    task automatic cyc();
        exp_t e;
        @(posedge clk);
        @(negedge clk);
        if (sb.size() == 0) begin
            compared++;
            mism++;
            $display("FAIL sb_empty got 0 entries want 1");
        end else begin
            e = sb.pop_front();
            check(e);
        end
    endtask

    task automatic addr(input int d, input logic w, input logic [2:0] sz,
                        input logic [31:0] a);
        hsel      = 3'b000;
        hsel[d]   = 1'b1;
        cur       = 2'(d);
        hwrite    = w;
        hsize     = sz;
        haddr     = a;
        htrans    = 2'b10;
    endtask

    task automatic idle();
        hsel   = 3'b000;
        htrans = 2'b00;
    endtask

    initial begin
        exp_t e;
        hsel = 3'b000; haddr = 32'd0; hwdata = 32'd0; hwrite = 1'b0;
        hsize = 3'd0; htrans = 2'b00; cur = 2'd0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        for (int d = 0; d < 3; d++) begin
            push("reset", d, 1'b1, 2'b00, 32'd0);
            cyc();
        end

        // back-to-back write then read of the same word
        addr(0, 1'b1, 3'd2, 32'h10);
        push("wr10", 0, 1'b1, 2'b00, 32'd0);
        cyc();
        hwdata = 32'hDEAD_BEEF;
        addr(0, 1'b0, 3'd2, 32'h10);
        push("raw10", 0, 1'b1, 2'b00, 32'hDEAD_BEEF);
        cyc();
        idle();
        push("idle0", 0, 1'b1, 2'b00, 32'd0);
        cyc();

        // byte and halfword lane merging
        addr(0, 1'b1, 3'd2, 32'h20);
        push("wr20", 0, 1'b1, 2'b00, 32'd0);
        cyc();
        hwdata = 32'h1122_3344;
        addr(0, 1'b1, 3'd0, 32'h22);
        push("wrb22", 0, 1'b1, 2'b00, 32'd0);
        cyc();
        hwdata = 32'h00AA_0000;
        addr(0, 1'b0, 3'd2, 32'h20);
        push("merge_b", 0, 1'b1, 2'b00, 32'h11AA_3344);
        cyc();
        addr(0, 1'b1, 3'd2, 32'h24);
        push("wr24", 0, 1'b1, 2'b00, 32'd0);
        cyc();
        hwdata = 32'h5566_7788;
        addr(0, 1'b1, 3'd1, 32'h26);
        push("wrh26", 0, 1'b1, 2'b00, 32'd0);
        cyc();
        hwdata = 32'hCAFE_F00D;
        addr(0, 1'b1, 3'd1, 32'h24);
        push("wrh24", 0, 1'b1, 2'b00, 32'd0);
        cyc();
        hwdata = 32'h1234_9999;
        addr(0, 1'b0, 3'd2, 32'h24);
        push("merge_h", 0, 1'b1, 2'b00, 32'hCAFE_9999);
        cyc();
        idle();
        push("idle1", 0, 1'b1, 2'b00, 32'd0);
        cyc();

        // misaligned halfword write must not touch memory
        addr(0, 1'b1, 3'd1, 32'h21);
        hwdata = 32'hFFFF_FFFF;
        push("hmis_e1", 0, 1'b0, 2'b01, 32'd0);
        push("hmis_e2", 0, 1'b1, 2'b01, 32'd0);
        cyc();
        idle();
        cyc();
        addr(0, 1'b0, 3'd2, 32'h20);
        push("hmis_rd", 0, 1'b1, 2'b00, 32'h11AA_3344);
        cyc();

        // oversize transfer
        addr(0, 1'b0, 3'd3, 32'h20);
        push("sz3_e1", 0, 1'b0, 2'b01, 32'd0);
        push("sz3_e2", 0, 1'b1, 2'b01, 32'd0);
        cyc();
        idle();
        cyc();

        // out-of-window read, legal read taken during ERR2
        addr(0, 1'b0, 3'd2, 32'h1000);
        push("oor_e1", 0, 1'b0, 2'b01, 32'd0);
        push("oor_e2", 0, 1'b1, 2'b01, 32'd0);
        cyc();
        idle();
        cyc();
        addr(0, 1'b0, 3'd2, 32'h10);
        push("after_err", 0, 1'b1, 2'b00, 32'hDEAD_BEEF);
        cyc();
        idle();
        push("idle2", 0, 1'b1, 2'b00, 32'd0);
        cyc();

        // two wait states
        addr(1, 1'b1, 3'd2, 32'h04);
        push("w2_wr_w0", 1, 1'b0, 2'b00, 32'd0);
        push("w2_wr_w1", 1, 1'b0, 2'b00, 32'd0);
        push("w2_wr_d", 1, 1'b1, 2'b00, 32'd0);
        cyc();
        idle();
        hwdata = 32'h0BAD_F00D;
        cyc();
        cyc();
        addr(1, 1'b0, 3'd2, 32'h04);
        push("w2_rd_w0", 1, 1'b0, 2'b00, 32'd0);
        push("w2_rd_w1", 1, 1'b0, 2'b00, 32'd0);
        push("w2_rd_d", 1, 1'b1, 2'b00, 32'h0BAD_F00D);
        cyc();
        idle();
        cyc();
        cyc();

        // misaligned word write: ERROR with no wait states, memory intact
        addr(1, 1'b1, 3'd2, 32'h06);
        hwdata = 32'hFFFF_FFFF;
        push("wmis_e1", 1, 1'b0, 2'b01, 32'd0);
        push("wmis_e2", 1, 1'b1, 2'b01, 32'd0);
        cyc();
        idle();
        cyc();
        addr(1, 1'b0, 3'd2, 32'h04);
        push("wmis_w0", 1, 1'b0, 2'b00, 32'd0);
        push("wmis_w1", 1, 1'b0, 2'b00, 32'd0);
        push("wmis_rd", 1, 1'b1, 2'b00, 32'h0BAD_F00D);
        cyc();
        idle();
        cyc();
        cyc();

        // three wait states, reset pulsed mid-wait aborts the write
        addr(2, 1'b1, 3'd2, 32'h30);
        push("w3_w0", 2, 1'b0, 2'b00, 32'd0);
        push("w3_w1", 2, 1'b0, 2'b00, 32'd0);
        push("w3_w2", 2, 1'b0, 2'b00, 32'd0);
        push("w3_d", 2, 1'b1, 2'b00, 32'd0);
        cyc();
        idle();
        hwdata = 32'h600D_CAFE;
        repeat (3) cyc();
        addr(2, 1'b1, 3'd2, 32'h30);
        push("abort_w0", 2, 1'b0, 2'b00, 32'd0);
        push("abort_w1", 2, 1'b0, 2'b00, 32'd0);
        cyc();
        idle();
        hwdata = 32'hBAD0_BAD0;
        cyc();
        rst_n = 1'b0;
        #1;
        e.tag = "async_rst"; e.d = 2; e.rdy = 1'b1;
        e.resp = 2'b00; e.rdata = 32'd0;
        check(e);
        #2;
        rst_n = 1'b1;
        push("post_rst", 2, 1'b1, 2'b00, 32'd0);
        cyc();
        addr(2, 1'b0, 3'd2, 32'h30);
        push("abort_rw0", 2, 1'b0, 2'b00, 32'd0);
        push("abort_rw1", 2, 1'b0, 2'b00, 32'd0);
        push("abort_rw2", 2, 1'b0, 2'b00, 32'd0);
        push("abort_rd", 2, 1'b1, 2'b00, 32'h600D_CAFE);
        cyc();
        idle();
        repeat (3) cyc();

        compared++;
        assert (sb.size() == 0) else begin
            mism++;
            $error("FAIL sb_drain got %0d entries want 0", sb.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mism);
        $finish;
    end

endmodule
